// File: rtl/rf_pkg.sv
// Shared constants and requester ids for the register-file writeback arbiter.
package rf_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned NUM_REGS = 2**ADDR_W;
   localparam int unsigned STALL_W  = 8;

   typedef enum logic {
      REQ_ALU  = 1'b0,
      REQ_LOAD = 1'b1
   } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grants, registered priority pointer.
module rr_arb2
   import rf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   output logic [1:0] grant_c
);

   req_id_t ptr;

   always_comb begin
      grant_c = 2'b00;
      case (valid)
         2'b01:   grant_c = 2'b01;
         2'b10:   grant_c = 2'b10;
         2'b11:   grant_c = (ptr == REQ_ALU) ? 2'b01 : 2'b10;
         default: grant_c = 2'b00;
      endcase
   end

   // Only a contested grant hands priority to the loser.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= REQ_ALU;
      end else if (&valid) begin
         ptr <= (ptr == REQ_ALU) ? REQ_LOAD : REQ_ALU;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register_file write port.
// Optional RF_R0_ZERO_EN: writes to r0 are accepted but suppressed, so r0 stays zero.
module rf_wb_arbiter #(
   parameter int unsigned DATA_W  = rf_pkg::DATA_W,
   parameter int unsigned ADDR_W  = rf_pkg::ADDR_W,
   parameter int unsigned STALL_W = rf_pkg::STALL_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [ADDR_W-1:0]      req0_dest,
   input  logic [DATA_W-1:0]      req0_data,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [ADDR_W-1:0]      req1_dest,
   input  logic [DATA_W-1:0]      req1_data,
   output logic                   reg_write_en,
   output logic [ADDR_W-1:0]      reg_write_dest,
   output logic [DATA_W-1:0]      reg_write_data,
   output logic [2**ADDR_W-1:0]   wb_pending,
   output logic [STALL_W-1:0]     stall_cnt
);

   localparam int unsigned NUM_REGS = 2**ADDR_W;

   logic [1:0]        grant_c;
   logic [ADDR_W-1:0] sel_dest_c;
   logic [DATA_W-1:0] sel_data_c;
   logic              write_c;
   logic              refused_c;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid   ({req1_valid, req0_valid}),
      .grant_c (grant_c)
   );

   assign req0_ready = grant_c[0];
   assign req1_ready = grant_c[1];

   // Winner's payload and whether it really produces a register_file write.
   always_comb begin
      sel_dest_c = req0_dest;
      sel_data_c = req0_data;
      if (grant_c[rf_pkg::REQ_LOAD]) begin
         sel_dest_c = req1_dest;
         sel_data_c = req1_data;
      end
`ifdef RF_R0_ZERO_EN
      write_c = (|grant_c) && (sel_dest_c != '0);
`else
      write_c = |grant_c;
`endif
      refused_c = (req0_valid & ~grant_c[0]) | (req1_valid & ~grant_c[1]);
   end

   // Output register refills every cycle; dest/data hold when nothing is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_en   <= 1'b0;
         reg_write_dest <= '0;
         reg_write_data <= '0;
         wb_pending     <= '0;
         stall_cnt      <= '0;
      end else begin
         reg_write_en <= write_c;
         if (|grant_c) begin
            reg_write_dest <= sel_dest_c;
            reg_write_data <= sel_data_c;
         end
         wb_pending <= write_c ? (NUM_REGS'(1) << sel_dest_c) : '0;
         if (refused_c && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, reset and saturation sequences, random traffic vs model.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [3:0]  req0_dest, req1_dest;
   logic [15:0] req0_data, req1_data;

   logic        req0_ready, req1_ready, reg_write_en;
   logic [3:0]  reg_write_dest;
   logic [15:0] reg_write_data, wb_pending;
   logic [7:0]  stall_cnt;

   logic        s_req0_ready, s_req1_ready, s_reg_write_en;
   logic [3:0]  s_reg_write_dest;
   logic [15:0] s_reg_write_data, s_wb_pending;
   logic [1:0]  s_stall_cnt;

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dest(req0_dest), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dest(req1_dest), .req1_data(req1_data),
      .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
      .wb_pending(wb_pending), .stall_cnt(stall_cnt)
   );

   rf_wb_arbiter #(.STALL_W(2)) dut_s (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_dest(req0_dest), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_dest(req1_dest), .req1_data(req1_data),
      .reg_write_en(s_reg_write_en), .reg_write_dest(s_reg_write_dest), .reg_write_data(s_reg_write_data),
      .wb_pending(s_wb_pending), .stall_cnt(s_stall_cnt)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit          m_ptr;
   bit          m_wen;
   logic [3:0]  m_dest;
   logic [15:0] m_data;
   int          m_stall, m_stall2;
   bit          m_acc0, m_acc1;
   logic        obs_r0, obs_r1;

   // Register file behind the write port, fed from the DUT outputs
   logic [15:0] rf_act [16];
   initial for (int i = 0; i < 16; i++) rf_act[i] = '0;
   always @(posedge clk) if (reg_write_en) rf_act[reg_write_dest] <= reg_write_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 1'b0; m_wen = 1'b0; m_dest = '0; m_data = '0;
      m_stall = 0; m_stall2 = 0;
   endtask

   task automatic drive_idle();
      req0_valid = 1'b0; req0_dest = '0; req0_data = '0;
      req1_valid = 1'b0; req1_dest = '0; req1_data = '0;
   endtask

   // One clock of traffic: check readies before the edge, registered outputs after it.
   task automatic step(input logic v0, input logic [3:0] d0, input logic [15:0] x0,
                       input logic v1, input logic [3:0] d1, input logic [15:0] x1);
      int          win;
      logic [3:0]  dst;
      logic [15:0] dat;
      @(negedge clk);
      req0_valid = v0; req0_dest = d0; req0_data = x0;
      req1_valid = v1; req1_dest = d1; req1_data = x1;
      #1;
      win = -1;
      if (v0 && v1)  win = int'(m_ptr);
      else if (v0)   win = 0;
      else if (v1)   win = 1;
      m_acc0 = (win == 0);
      m_acc1 = (win == 1);
      obs_r0 = req0_ready;
      obs_r1 = req1_ready;
      check("req0_ready", 32'(req0_ready), 32'(m_acc0));
      check("req1_ready", 32'(req1_ready), 32'(m_acc1));
      @(posedge clk);
      #1;
      if (win >= 0) begin
         dst = (win == 1) ? d1 : d0;
         dat = (win == 1) ? x1 : x0;
         m_dest = dst;
         m_data = dat;
`ifdef RF_R0_ZERO_EN
         m_wen = (dst != 4'd0);
`else
         m_wen = 1'b1;
`endif
         if (v0 && v1) m_ptr = (win == 0);
      end else begin
         m_wen = 1'b0;
      end
      if (v0 && v1) begin
         if (m_stall < 255) m_stall++;
         if (m_stall2 < 3)  m_stall2++;
      end
      check("reg_write_en",   32'(reg_write_en),   32'(m_wen));
      check("reg_write_dest", 32'(reg_write_dest), 32'(m_dest));
      check("reg_write_data", 32'(reg_write_data), 32'(m_data));
      check("wb_pending",     32'(wb_pending),     m_wen ? (32'd1 << m_dest) : 32'd0);
      check("stall_cnt",      32'(stall_cnt),      32'(m_stall));
      check("stall_cnt_w2",   32'(s_stall_cnt),    32'(m_stall2));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic v0; logic [3:0] d0; logic [15:0] x0;
      logic v1; logic [3:0] d1; logic [15:0] x1;
      logic r0; logic r1; logic wen;
      logic [3:0] dest; logic [15:0] data; logic [15:0] pend;
   } vec_t;

   vec_t tbl [11];

   logic        h0v, h1v;
   logic [3:0]  h0d, h1d;
   logic [15:0] h0x, h1x;

   initial begin
      tbl[0]  = '{1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd3, 16'hBEEF, 16'h0008};
      tbl[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 16'hBEEF, 16'h0000};
      tbl[2]  = '{1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB, 1'b1, 1'b0, 1'b1, 4'd5, 16'hAAAA, 16'h0020};
      tbl[3]  = '{1'b1, 4'd5, 16'hCCCC, 1'b1, 4'd6, 16'hBBBB, 1'b0, 1'b1, 1'b1, 4'd6, 16'hBBBB, 16'h0040};
      tbl[4]  = '{1'b1, 4'd5, 16'hCCCC, 1'b1, 4'd6, 16'hDDDD, 1'b1, 1'b0, 1'b1, 4'd5, 16'hCCCC, 16'h0020};
      tbl[5]  = '{1'b1, 4'd5, 16'hEEEE, 1'b1, 4'd6, 16'hDDDD, 1'b0, 1'b1, 1'b1, 4'd6, 16'hDDDD, 16'h0040};
      tbl[6]  = '{1'b1, 4'd5, 16'hEEEE, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd5, 16'hEEEE, 16'h0020};
      tbl[7]  = '{1'b1, 4'd7, 16'h1111, 1'b1, 4'd7, 16'h2222, 1'b1, 1'b0, 1'b1, 4'd7, 16'h1111, 16'h0080};
      tbl[8]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h2222, 1'b0, 1'b1, 1'b1, 4'd7, 16'h2222, 16'h0080};
`ifdef RF_R0_ZERO_EN
      tbl[9]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd0, 16'hFFFF, 16'h0000};
`else
      tbl[9]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'd0, 16'hFFFF, 16'h0001};
`endif
      tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'hFFFF, 16'h0000};

      // Power-on reset
      rst = 1'b1;
      drive_idle();
      model_reset();
      #12;
      check("rst_wen",     32'(reg_write_en),   32'd0);
      check("rst_dest",    32'(reg_write_dest), 32'd0);
      check("rst_data",    32'(reg_write_data), 32'd0);
      check("rst_pending", 32'(wb_pending),     32'd0);
      check("rst_stall",   32'(stall_cnt),      32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset asserted while a grant sits in the output register
      step(1'b1, 4'd2, 16'h55AA, 1'b1, 4'd12, 16'h1234);
      step(1'b1, 4'd2, 16'h77AA, 1'b1, 4'd12, 16'h1234);
      #2;
      rst = 1'b1;
      drive_idle();
      model_reset();
      #1;
      check("midrst_wen",     32'(reg_write_en),   32'd0);
      check("midrst_dest",    32'(reg_write_dest), 32'd0);
      check("midrst_data",    32'(reg_write_data), 32'd0);
      check("midrst_pending", 32'(wb_pending),     32'd0);
      check("midrst_stall",   32'(stall_cnt),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202);
      check("post_rst_first_grant_r0", 32'(obs_r0), 32'd1);

      // Directed vector table from a clean reset
      do_reset();
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].v0, tbl[i].d0, tbl[i].x0, tbl[i].v1, tbl[i].d1, tbl[i].x1);
         check($sformatf("tbl%0d_r0", i),   32'(obs_r0),         32'(tbl[i].r0));
         check($sformatf("tbl%0d_r1", i),   32'(obs_r1),         32'(tbl[i].r1));
         check($sformatf("tbl%0d_wen", i),  32'(reg_write_en),   32'(tbl[i].wen));
         check($sformatf("tbl%0d_dest", i), 32'(reg_write_dest), 32'(tbl[i].dest));
         check($sformatf("tbl%0d_data", i), 32'(reg_write_data), 32'(tbl[i].data));
         check($sformatf("tbl%0d_pend", i), 32'(wb_pending),     32'(tbl[i].pend));
      end
      check("tbl_stall_cnt",    32'(stall_cnt),   32'd5);
      check("tbl_stall_cnt_w2", 32'(s_stall_cnt), 32'd3);
      check("rf_r3",  32'(rf_act[3]), 32'h0000BEEF);
      check("rf_r5",  32'(rf_act[5]), 32'h0000EEEE);
      check("rf_r6",  32'(rf_act[6]), 32'h0000DDDD);
      check("rf_r7_later_grant", 32'(rf_act[7]), 32'h00002222);
`ifdef RF_R0_ZERO_EN
      check("rf_r0_zero", 32'(rf_act[0]), 32'h00000000);
`else
      check("rf_r0_ffff", 32'(rf_act[0]), 32'h0000FFFF);
`endif

      // Random traffic; refused requesters hold their payload
      m_acc0 = 1'b1; m_acc1 = 1'b1;
      h0v = 1'b0; h1v = 1'b0; h0d = '0; h1d = '0; h0x = '0; h1x = '0;
      for (int i = 0; i < 300; i++) begin
         if (!(h0v && !m_acc0)) begin
            h0v = 1'($urandom_range(0, 1)); h0d = 4'($urandom); h0x = 16'($urandom);
         end
         if (!(h1v && !m_acc1)) begin
            h1v = 1'($urandom_range(0, 1)); h1d = 4'($urandom); h1x = 16'($urandom);
         end
         step(h0v, h0d, h0x, h1v, h1d, h1x);
      end

      // Long contention drives both counters into saturation
      do_reset();
      for (int i = 0; i < 260; i++) begin
         step(1'b1, 4'd5, 16'h0A0A, 1'b1, 4'd6, 16'h0B0B);
      end
      check("sat_stall_cnt",    32'(stall_cnt),   32'h000000FF);
      check("sat_stall_cnt_w2", 32'(s_stall_cnt), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
